imem_server: RTL and testbench



---
 rtl/imem_pkg.sv | 16 +
 rtl/imem_server_if.sv | 29 ++
 rtl/imem_array.sv | 32 +++
 rtl/imem_server.sv | 132 +++++++++++++
 tb/tb_imem_server.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared constants and types for the instruction-memory responder.
//   NOP     - value returned for out-of-range or misaligned fetches (addi x0,x0,0)
//   CNT_W   - width of the latency down-counter (LATENCY up to 15)
//   state_e - responder FSM states
package imem_pkg;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int          CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/imem_server_if.sv
// imem_server_if: fetch and loader signals between the core/boot side and
// the instruction-memory responder.
//   ins_ren/ins_addr        - fetch request (core exIns_ren / exIns_addr)
//   ins_valid/ins_data      - one-cycle response strobe and instruction
//   load_wen/addr/data      - loader write port
//   busy                    - high while a fetch is outstanding
// modport master: core / loader side.  modport slave: imem_server.
interface imem_server_if;

  logic        ins_ren;
  logic [31:0] ins_addr;
  logic        ins_valid;
  logic [31:0] ins_data;
  logic        load_wen;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        busy;

  modport master (
    output ins_ren, ins_addr, load_wen, load_addr, load_data,
    input  ins_valid, ins_data, busy
  );

  modport slave (
    input  ins_ren, ins_addr, load_wen, load_addr, load_data,
    output ins_valid, ins_data, busy
  );

endinterface

// File: rtl/imem_array.sv
// imem_array: word-addressed program storage.
//   clk        - clock
//   we_i       - write enable (already qualified by address decode)
//   wr_idx_i   - write word index
//   wr_data_i  - write data
//   rd_idx_i   - read word index
//   rd_data_o  - asynchronous read data
// The read port is combinational, so a register capturing rd_data_o on the
// same edge as a write to the same word sees the old contents.
// Contents are deliberately not reset.
module imem_array #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] wr_idx_i,
  input  logic [31:0]           wr_data_i,
  input  logic [DEPTH_LOG2-1:0] rd_idx_i,
  output logic [31:0]           rd_data_o
);

  logic [31:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/imem_server.sv
// imem_server: instruction-memory responder for the core's external fetch port.
// Accepts one fetch at a time, captures the addressed word at acceptance and
// returns it with a one-cycle ins_valid pulse after LATENCY cycles.
//   clk    - clock
//   rst    - synchronous, active-high reset
//   bus    - imem_server_if.slave (fetch request/response, loader, busy)
//   fault  - sticky bad-access flag, only present when IMEM_FAULT_EN is defined
// Parameters: DEPTH_LOG2 (array depth in words, log2), LATENCY (1..15),
// BASE_ADDR (byte address of word 0).
// Optional build macro: IMEM_FAULT_EN.
//
// state | meaning
// IDLE  | ready; a fetch request is accepted here
// WAIT  | fetch accepted, counting down the remaining latency
// RESP  | ins_valid high for one cycle with the captured word
module imem_server
  import imem_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  imem_server_if.slave  bus
`ifdef IMEM_FAULT_EN
  ,
  output logic          fault
`endif
);

  localparam logic [31:0]      SPAN     = 32'd4 << DEPTH_LOG2;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [31:0]            data_q, data_d;

  logic [31:0]            fetch_off;
  logic                   fetch_ok;
  logic [DEPTH_LOG2-1:0]  fetch_idx;
  logic [31:0]            load_off;
  logic                   load_ok;
  logic [DEPTH_LOG2-1:0]  load_idx;
  logic [31:0]            rd_word;
  logic                   accept;

  // Address decode: offset must fall inside the array and be word aligned.
  assign fetch_off = bus.ins_addr - BASE_ADDR;
  assign fetch_ok  = (fetch_off < SPAN) && (fetch_off[1:0] == 2'b00);
  assign fetch_idx = fetch_off[DEPTH_LOG2+1:2];

  assign load_off  = bus.load_addr - BASE_ADDR;
  assign load_ok   = (load_off < SPAN) && (load_off[1:0] == 2'b00);
  assign load_idx  = load_off[DEPTH_LOG2+1:2];

  imem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk       (clk),
    .we_i      (bus.load_wen && load_ok),
    .wr_idx_i  (load_idx),
    .wr_data_i (bus.load_data),
    .rd_idx_i  (fetch_idx),
    .rd_data_o (rd_word)
  );

  assign accept = (state_q == IDLE) && bus.ins_ren;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= NOP;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = fetch_ok ? rd_word : NOP;
          cnt_d   = CNT_INIT;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        // The counter reaches zero on the same edge that enters RESP, so the
        // pulse sits in the LATENCY-th cycle after acceptance and the slot
        // after RESP is free again (one fetch per LATENCY+1 cycles).
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ins_valid = (state_q == RESP);
  assign bus.ins_data  = data_q;
  assign bus.busy      = (state_q != IDLE);

`ifdef IMEM_FAULT_EN
  logic fault_q;

  // Sticky until reset: bad fetches are flagged only when accepted, bad
  // loader writes on any cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if ((accept && !fetch_ok) || (bus.load_wen && !load_ok)) begin
      fault_q <= 1'b1;
    end
  end

  assign fault = fault_q;
`endif

endmodule

// File: tb/tb_imem_server.sv
module tb_imem_server;
  import imem_pkg::*;

  localparam int          LAT  = 2;
  localparam int          DLOG = 10;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
`ifdef IMEM_FAULT_EN
  logic fault;
`endif

  imem_server_if bus_if ();

  imem_server #(
    .DEPTH_LOG2 (DLOG),
    .LATENCY    (LAT),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus_if)
`ifdef IMEM_FAULT_EN
    ,
    .fault (fault)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: program contents plus a timeline of the one fetch in flight.
  logic [31:0] mem_m [1 << DLOG];
  logic [31:0] pre   [64];
  int          edge_n    = 0;
  int          acc_edge  = -100;
  int          free_edge = 0;
  bit          pending   = 1'b0;
  bit          m_fault   = 1'b0;
  logic [31:0] m_data    = NOP;
  bit          acc_now   = 1'b0;
  logic        obs_valid;
  logic [31:0] obs_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (off < (32'd4 << DLOG)) && (off % 4 == 0);
  endfunction

  function automatic int word_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] bad [4];
    bad = '{32'h0000_1000, 32'h0000_0002, 32'hFFFF_FFFC, 32'h0000_0101};
    if ($urandom_range(9) < 8) return 32'($urandom_range(63)) * 4;
    return bad[$urandom_range(3)];
  endfunction

  // One clock: drive inputs, advance the model at the edge, check outputs 1ns later.
  task automatic step(input logic ren, input logic [31:0] a, input logic wen,
                      input logic [31:0] la, input logic [31:0] ld, input logic r);
    bit exp_valid, exp_busy;
    bus_if.ins_ren   = ren;
    bus_if.ins_addr  = a;
    bus_if.load_wen  = wen;
    bus_if.load_addr = la;
    bus_if.load_data = ld;
    rst              = r;
    @(posedge clk);
    edge_n++;
    acc_now = 1'b0;
    if (r) begin
      pending   = 1'b0;
      free_edge = edge_n + 1;
      m_data    = NOP;
      m_fault   = 1'b0;
    end else if (ren && edge_n >= free_edge) begin
      acc_now   = 1'b1;
      pending   = 1'b1;
      acc_edge  = edge_n;
      free_edge = edge_n + LAT + 1;
      if (addr_ok(a)) m_data = mem_m[word_idx(a)];
      else begin
        m_data  = NOP;
        m_fault = 1'b1;
      end
    end
    if (wen) begin
      if (addr_ok(la)) mem_m[word_idx(la)] = ld;
      else if (!r) m_fault = 1'b1;
    end
    #1;
    exp_busy  = pending && (edge_n <= acc_edge + LAT - 1);
    exp_valid = pending && (edge_n == acc_edge + LAT - 1);
    obs_valid = bus_if.ins_valid;
    obs_data  = bus_if.ins_data;
    check("valid", {31'b0, obs_valid}, {31'b0, exp_valid});
    check("busy", {31'b0, bus_if.busy}, {31'b0, exp_busy});
    if (exp_valid || r) check(r ? "rst_data" : "data", obs_data, m_data);
`ifdef IMEM_FAULT_EN
    check("fault", {31'b0, fault}, {31'b0, m_fault});
`endif
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic load(input logic [31:0] la, input logic [31:0] ld);
    step(1'b0, 32'h0, 1'b1, la, ld, 1'b0);
  endtask

  // Issue a fetch (ren held until accepted), then watch for its response.
  task automatic fetch(input logic [31:0] a, output logic [31:0] d,
                       output int lat, output int npulse);
    int t0;
    t0 = -1;
    d = '0;
    lat = -1;
    npulse = 0;
    for (int i = 0; i < 20 && t0 < 0; i++) begin
      step(1'b1, a, 1'b0, 32'h0, 32'h0, 1'b0);
      if (acc_now) t0 = edge_n;
    end
    if (t0 >= 0 && obs_valid) begin
      npulse++;
      lat = edge_n + 1 - t0;
      d   = obs_data;
    end
    for (int i = 0; i < LAT + 3; i++) begin
      idle();
      if (obs_valid) begin
        npulse++;
        if (lat < 0) begin
          lat = edge_n + 1 - t0;
          d   = obs_data;
        end
      end
    end
  endtask

  initial begin
    logic [31:0] d;
    int          lat, np, k, npl;
    logic [31:0] b2b_addr [3];
    int          pl_edge  [$];
    logic [31:0] pl_data  [$];

    // Reset, then idle.
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      idle();
      check("idle_data", bus_if.ins_data, NOP);
    end

    // Preload words 0..63.
    for (int i = 0; i < 64; i++) pre[i] = $urandom;
    pre[1] = 32'h0050_0093;
    pre[4] = 32'hAAAA_AAAA;
    for (int i = 0; i < 64; i++) load(32'(i) * 4, pre[i]);

    // Basic fetch.
    fetch(32'h4, d, lat, np);
    check("basic_data", d, 32'h0050_0093);
    check("basic_lat", 32'(lat), 32'(LAT));
    check("basic_pulses", 32'(np), 32'd1);

    // Back-to-back with ren held high.
    b2b_addr = '{32'h0, 32'h4, 32'h8};
    k = 0;
    for (int i = 0; i < 40 && (k < 3 || pending); i++) begin
      if (k < 3) step(1'b1, b2b_addr[k], 1'b0, 32'h0, 32'h0, 1'b0);
      else       idle();
      if (acc_now) k++;
      if (obs_valid) begin
        pl_edge.push_back(edge_n);
        pl_data.push_back(obs_data);
      end
    end
    for (int i = 0; i < LAT + 2; i++) begin
      idle();
      if (obs_valid) begin
        pl_edge.push_back(edge_n);
        pl_data.push_back(obs_data);
      end
    end
    check("b2b_pulses", 32'(pl_edge.size()), 32'd3);
    for (int i = 0; i < pl_data.size() && i < 3; i++) check("b2b_data", pl_data[i], pre[i]);
    for (int i = 1; i < pl_edge.size(); i++)
      check("b2b_gap", 32'(pl_edge[i] - pl_edge[i-1]), 32'(LAT + 1));

    // Out of range and misaligned.
    fetch(32'h0000_1000, d, lat, np);
    check("oor_data", d, NOP);
    check("oor_pulses", 32'(np), 32'd1);
`ifdef IMEM_FAULT_EN
    check("fault_set", {31'b0, fault}, 32'd1);
`endif
    fetch(32'h0000_0002, d, lat, np);
    check("mis_data", d, NOP);
    fetch(32'h0000_0008, d, lat, np);
    check("good_after_bad", d, pre[2]);
`ifdef IMEM_FAULT_EN
    check("fault_sticky", {31'b0, fault}, 32'd1);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("fault_clr", {31'b0, fault}, 32'd0);
`endif

    // Fetch accept and load to the same word on the same edge.
    step(1'b1, 32'h10, 1'b1, 32'h10, 32'h5555_5555, 1'b0);
    check("coll_accept", {31'b0, acc_now}, 32'd1);
    d = '0;
    npl = 0;
    if (obs_valid) begin
      d = obs_data;
      npl++;
    end
    for (int i = 0; i < LAT + 3; i++) begin
      idle();
      if (obs_valid) begin
        d = obs_data;
        npl++;
      end
    end
    check("coll_old", d, 32'hAAAA_AAAA);
    check("coll_pulses", 32'(npl), 32'd1);
    fetch(32'h10, d, lat, np);
    check("coll_new", d, 32'h5555_5555);

    // Reset while the fetch is waiting.
    step(1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("rst_busy", {31'b0, bus_if.busy}, 32'd0);
    npl = 0;
    for (int i = 0; i < LAT + 3; i++) begin
      idle();
      if (obs_valid) npl++;
    end
    check("rst_nopulse", 32'(npl), 32'd0);
    fetch(32'h8, d, lat, np);
    check("post_rst_data", d, pre[2]);
    check("post_rst_lat", 32'(lat), 32'(LAT));

    // Randomised traffic against the model.
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(1)), rand_addr(), ($urandom_range(3) == 0), rand_addr(),
           $urandom, ($urandom_range(59) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
